reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Y86-64 program register file; sits directly upstream of the ALU.
- Supplies valA/valB operands (aluA/aluB source) during decode.
- Accepts the ALU result (valE) and memory result (valM) for write-back.
- 15 architectural 64-bit registers, IDs 0x0–0xE; ID 0xF means "no register".

Parameters:
- NREG, 15, number of architectural registers; IDs NREG..15 are treated as "none".
- RSP_INIT, 64'h0, reset value of register 4 (%rsp); all other registers reset to 0.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- srcA  input  4  read port A register ID.
- srcB  input  4  read port B register ID.
- valA  output  64  contents of srcA; 0 when srcA = 0xF.
- valB  output  64  contents of srcB; 0 when srcB = 0xF.
- dstE  input  4  write port E register ID; 0xF = no write.
- valE  input  64  write data for port E (ALU result).
- dstM  input  4  write port M register ID; 0xF = no write.
- valM  input  64  write data for port M (memory result).
- wrEn  input  1  global write enable; when 0, both ports are suppressed (stall).
- rspOut  output  64  current %rsp (register 4), for debug/trace.

Behaviour:
- Reset: rst_n low clears every register asynchronously to 0, except reg 4 = RSP_INIT. While rst_n is low, writes are ignored and outputs reflect reset values. Deassertion takes effect on the next rising edge.
- Reads are combinational and take effect in the same cycle: valA = R[srcA], valB = R[srcB]. Any ID ≥ NREG (including 0xF) reads 64'h0.
- Writes are synchronous on the rising clk edge, only when wrEn = 1 and rst_n = 1:
  - Port E writes valE into R[dstE] if dstE < NREG.
  - Port M writes valM into R[dstM] if dstM < NREG.
  - Both ports may write different registers in the same cycle (e.g. popq: dstE = rsp, dstM = rA).
- Port collision: if dstE = dstM and both are valid, port M wins; valE is discarded. This gives "popq %rsp" its architectural result.
- Read/write same cycle: without bypass, reads return the pre-edge (old) value. The new value is visible after the edge.
- Write to ID 0xF: no state change and no side effect.
- rspOut always equals R[4], including the reset value.
- Latency: read 0 cycles; write 1 edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: read ports forward in-flight write data combinationally. If srcX matches a valid dstM with wrEn = 1, valX = valM. Otherwise, if it matches a valid dstE, valX = valE. Otherwise valX = stored value. Priority M > E matches the collision rule. rspOut is not bypassed.
- Undefined: pure storage read as above; the bypass logic is absent.

Decomposition:
- Shared package (y86_pkg): register-ID constants RRSP = 4'h4, RNONE = 4'hF; NREG; ICODE constants (IPOPQ = 4'hB etc.); 64-bit word typedef.
- One sub-module is natural: reg_read_port (ID decode plus the optional bypass mux), instantiated twice for A and B.
- The storage array and write logic stay in reg_file.

Test Plan:
- Reset: hold rst_n = 0 with RSP_INIT = 64'h200, then read srcA = 4, srcB = 0. Expect valA = 64'h200, valB = 0, rspOut = 64'h200.
- Dual write: dstE = 3, valE = 64'hA, dstM = 7, valM = 64'hB, wrEn = 1, one edge. Then srcA = 3, srcB = 7 gives valA = 64'hA, valB = 64'hB.
- Collision: dstE = dstM = 4, valE = 64'h1F8, valM = 64'h55, one edge. Expect rspOut = 64'h55.
- Stall and none: wrEn = 0 with dstE = 2, valE = 1 leaves R[2] = 0. dstE = 0xF with srcA = 0xF: no register changes, valA = 0.
- Same-cycle read of a write: srcA = dstE = 5, valE = 64'hCAFE, R[5] = 0 before the edge. Without REGFILE_BYPASS_EN, valA = 0 pre-edge and 64'hCAFE post-edge. With it, valA = 64'hCAFE pre-edge.
- Async reset mid-operation: write R[1] = 64'h9, then drop rst_n between edges. Expect valA(src 1) = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared Y86-64 constants, word type and register-ID helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    typedef logic [63:0] word_t;

    localparam int        NREG  = 15;
    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // IDs at or above the implemented register count behave as "no register".
    function automatic logic isReg(input logic [3:0] id, input int nreg);
        return int'(id) < nreg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : reg_read_port
//  Description : One register-file read port: ID decode and, when
//                REGFILE_BYPASS_EN is defined, write-data forwarding (M > E).
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_read_port
    import y86_pkg::*;
#(
    parameter int NREG = y86_pkg::NREG
) (
    input  logic [3:0]  src,
    input  word_t       regs [NREG],
    input  logic [3:0]  dstE,
    input  word_t       valE,
    input  logic [3:0]  dstM,
    input  word_t       valM,
    input  logic        wrEn,
    output word_t       val
);

    word_t w_stored;

    always_comb begin
        w_stored = '0;
        if (isReg(src, NREG)) begin
            w_stored = regs[src];
        end
    end

`ifdef REGFILE_BYPASS_EN
    // An invalid src can never equal a valid dst, so no separate src check.
    always_comb begin
        val = w_stored;
        if (wrEn && isReg(dstM, NREG) && (src == dstM)) begin
            val = valM;
        end else if (wrEn && isReg(dstE, NREG) && (src == dstE)) begin
            val = valE;
        end
    end
`else
    logic w_unused;

    assign val      = w_stored;
    assign w_unused = ^{dstE, valE, dstM, valM, wrEn};
`endif

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : Y86-64 register file, two combinational read ports and two
//                write ports (E, M). Optional macro: REGFILE_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import y86_pkg::*;
#(
    parameter int    NREG     = y86_pkg::NREG,
    parameter word_t RSP_INIT = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA,
    output logic [63:0] valB,
    input  logic [3:0]  dstE,
    input  logic [63:0] valE,
    input  logic [3:0]  dstM,
    input  logic [63:0] valM,
    input  logic        wrEn,
    output logic [63:0] rspOut
);

    word_t r_regs [NREG];
    logic  w_wrActive;
    logic  w_eValid;
    logic  w_mValid;

    // Gating with rst_n keeps forwarded data off the outputs during reset.
    assign w_wrActive = wrEn & rst_n;
    assign w_mValid   = isReg(dstM, NREG);
    assign w_eValid   = isReg(dstE, NREG) && !(w_mValid && (dstM == dstE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= (i == int'(RRSP)) ? RSP_INIT : '0;
            end
        end else if (wrEn) begin
            if (w_eValid) begin
                r_regs[dstE] <= valE;
            end
            if (w_mValid) begin
                r_regs[dstM] <= valM;
            end
        end
    end

    reg_read_port #(.NREG(NREG)) u_readA (
        .src  (srcA),
        .regs (r_regs),
        .dstE (dstE),
        .valE (valE),
        .dstM (dstM),
        .valM (valM),
        .wrEn (w_wrActive),
        .val  (valA)
    );

    reg_read_port #(.NREG(NREG)) u_readB (
        .src  (srcB),
        .regs (r_regs),
        .dstE (dstE),
        .valE (valE),
        .dstM (dstM),
        .valM (valM),
        .wrEn (w_wrActive),
        .val  (valB)
    );

    generate
        if (NREG > int'(RRSP)) begin : g_rsp
            assign rspOut = r_regs[RRSP];
        end else begin : g_noRsp
            assign rspOut = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file
//  Description : Self-checking bench for reg_file (vector table, corner
//                sequences, randomized traffic against an array model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    localparam logic [63:0] RSPI = 64'h200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valE, valM, valA, valB, rspOut;
    logic        wrEn;

    int nTests = 0;
    int nFail  = 0;

    logic [63:0] model [16];

    typedef struct {
        logic [3:0]  dE;
        logic [63:0] vE;
        logic [3:0]  dM;
        logic [63:0] vM;
        logic        we;
        logic [3:0]  sA;
        logic [3:0]  sB;
        logic [63:0] eA;
        logic [63:0] eB;
        logic [63:0] eRsp;
    } vec_t;

    vec_t vecs [8];

    reg_file #(.NREG(15), .RSP_INIT(RSPI)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .srcA   (srcA),
        .srcB   (srcB),
        .valA   (valA),
        .valB   (valB),
        .dstE   (dstE),
        .valE   (valE),
        .dstM   (dstM),
        .valM   (valM),
        .wrEn   (wrEn),
        .rspOut (rspOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model commit: E first, then M, so M naturally wins a collision; slot 15 is a sink.
    task automatic commit();
        if (wrEn) begin
            model[dstE] = valE;
            model[dstM] = valM;
        end
    endtask

    function automatic logic [63:0] mRead(input logic [3:0] id);
`ifdef REGFILE_BYPASS_EN
        if (wrEn && dstM != 4'hF && id == dstM) return valM;
        if (wrEn && dstE != 4'hF && id == dstE) return valE;
`endif
        return (id == 4'hF) ? 64'h0 : model[id];
    endfunction

    task automatic idleWrites();
        wrEn = 1'b0;
        dstE = 4'hF;
        dstM = 4'hF;
        valE = '0;
        valM = '0;
    endtask

    initial begin
        vecs[0] = '{4'h3, 64'hA,    4'h7, 64'hB,    1'b1, 4'h3, 4'h7, 64'hA,    64'hB,    64'h200};
        vecs[1] = '{4'h4, 64'h1F8,  4'h4, 64'h55,   1'b1, 4'h4, 4'h4, 64'h55,   64'h55,   64'h55};
        vecs[2] = '{4'h2, 64'h1,    4'h6, 64'h2,    1'b0, 4'h2, 4'h6, 64'h0,    64'h0,    64'h55};
        vecs[3] = '{4'hF, 64'hDEAD, 4'hF, 64'hBEEF, 1'b1, 4'hF, 4'h3, 64'h0,    64'hA,    64'h55};
        vecs[4] = '{4'h0, 64'h1111, 4'hE, 64'h2222, 1'b1, 4'h0, 4'hE, 64'h1111, 64'h2222, 64'h55};
        vecs[5] = '{4'h4, 64'h77,   4'hF, 64'h0,    1'b1, 4'h4, 4'h7, 64'h77,   64'hB,    64'h77};
        vecs[6] = '{4'hF, 64'h0,    4'h3, 64'hC,    1'b1, 4'h3, 4'hF, 64'hC,    64'h0,    64'h77};
        vecs[7] = '{4'h5, 64'h5,    4'h5, 64'h6,    1'b0, 4'h5, 4'h5, 64'h0,    64'h0,    64'h77};

        for (int i = 0; i < 16; i++) model[i] = '0;
        model[4] = RSPI;

        // Reset with a write attempt that must be ignored.
        srcA = 4'h4; srcB = 4'h0;
        dstE = 4'h3; valE = 64'h99; dstM = 4'hF; valM = '0; wrEn = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("reset_valA_rsp", valA, RSPI);
        check("reset_valB_r0", valB, 64'h0);
        check("reset_rspOut", rspOut, RSPI);
        srcA = 4'h3;
        #1 check("reset_write_ignored", valA, 64'h0);
        idleWrites();
        rst_n = 1'b1;
        tick();

        // Vector table: one write edge, then a read-back with the write ports idle.
        for (int i = 0; i < 8; i++) begin
            dstE = vecs[i].dE; valE = vecs[i].vE;
            dstM = vecs[i].dM; valM = vecs[i].vM; wrEn = vecs[i].we;
            commit();
            tick();
            idleWrites();
            srcA = vecs[i].sA; srcB = vecs[i].sB;
            #1;
            check($sformatf("vec%0d_valA", i), valA, vecs[i].eA);
            check($sformatf("vec%0d_valB", i), valB, vecs[i].eB);
            check($sformatf("vec%0d_rspOut", i), rspOut, vecs[i].eRsp);
        end

        // Same-cycle read of a write to R[5] (currently 0).
        srcA = 4'h5; srcB = 4'h0;
        dstE = 4'h5; valE = 64'hCAFE; dstM = 4'hF; wrEn = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdwr_pre_edge", valA, 64'hCAFE);
`else
        check("rdwr_pre_edge", valA, 64'h0);
`endif
        commit();
        tick();
        idleWrites();
        #1 check("rdwr_post_edge", valA, 64'hCAFE);

        // Randomized traffic against the array model.
        for (int n = 0; n < 300; n++) begin
            dstE = 4'($urandom_range(0, 15));
            dstM = ($urandom_range(0, 3) == 0) ? dstE : 4'($urandom_range(0, 15));
            valE = {$urandom, $urandom};
            valM = {$urandom, $urandom};
            wrEn = ($urandom_range(0, 4) != 0);
            srcA = ($urandom_range(0, 2) == 0) ? dstM : 4'($urandom_range(0, 15));
            srcB = ($urandom_range(0, 2) == 0) ? dstE : 4'($urandom_range(0, 15));
            #1;
            check("rand_valA", valA, mRead(srcA));
            check("rand_valB", valB, mRead(srcB));
            check("rand_rspOut", rspOut, model[4]);
            commit();
            tick();
        end

        // Async reset mid-operation.
        idleWrites();
        dstE = 4'h1; valE = 64'h9; wrEn = 1'b1;
        commit();
        tick();
        idleWrites();
        srcA = 4'h1; srcB = 4'h4;
        #1 check("async_pre_reset", valA, 64'h9);
        #2 rst_n = 1'b0;
        #1;
        check("async_valA_cleared", valA, 64'h0);
        check("async_valB_rsp", valB, RSPI);
        check("async_rspOut", rspOut, RSPI);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
